slow_set: RTL and testbench

Parametrised successor to the accelerator's slow-mode settings register. Software writes it by issuing a bus write into the settings window; the write data is carried on address lines. The block holds per-peripheral slow-enable bits and a slow-timeout value. It also runs a timeout counter that keeps the accelerator in slow mode for a programmable number of timebase ticks after each access to a slow-enabled peripheral.

---
 rtl/set_pkg.sv | 29 ++
 rtl/slow_timer.sv | 39 +++
 rtl/slow_set.sv | 120 ++++++++++++
 tb/tb_slow_set.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/set_pkg.sv
// set_pkg: default geometry, reset values and write-data field offsets for
// the slow-mode settings register (slow_set) and its timeout counter.
package set_pkg;

  // Default geometry: 7 slow-enable channels, 4-bit timeout.
  localparam int NCH_DEF = 7;
  localparam int TW_DEF  = 4;

  // Default reset contents of the settings register.
  localparam logic [NCH_DEF-1:0] RST_EN_DEF = 7'b0111111;
  localparam logic [TW_DEF-1:0]  RST_TO_DEF = 4'h3;

  // Write data rides on address bits starting at A[1]; A[0] is not used.
  localparam int EN_LSB = 1;

  // Timeout field sits directly above the enable field.
  function automatic int to_lsb(input int nch);
    return EN_LSB + nch;
  endfunction

  // Lock request sits directly above the timeout field.
  function automatic int lock_bit(input int nch, input int tw);
    return to_lsb(nch) + tw;
  endfunction

  localparam int TO_LSB   = to_lsb(NCH_DEF);
  localparam int LOCK_BIT = lock_bit(NCH_DEF, TW_DEF);

endpackage

// File: rtl/slow_timer.sv
// slow_timer: slow-mode hold counter. A load sets the count to LoadVal;
// otherwise each Tick decrements a nonzero count. Hold is high while the
// count is nonzero and comes straight from the count register.
module slow_timer #(
  parameter int TW = 4
) (
  input  logic          CLK,
  input  logic          nPOR,
  input  logic          Load,
  input  logic [TW-1:0] LoadVal,
  input  logic          Tick,
  output logic          Hold
);

  logic [TW-1:0] cnt_q, cnt_d;

  // Next count: load wins over tick; tick stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (Load) begin
      cnt_d = LoadVal;
    end else if (Tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nPOR) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Hold decodes the count register directly, adding no pipeline stage.
  assign Hold = (cnt_q != '0);

endmodule

// File: rtl/slow_set.sv
// slow_set: slow-mode settings register with a one-shot write front end,
// per-channel slow enables, programmable timeout and the hold counter.
// Optional feature macro: SET_LOCK_EN (write-once lock of the settings).
//
// Write handshake: a bus write is "valid" while BACT && SetCSWR is high;
// there is no ready/stall. The request and address are registered on the
// same edge, and the next edge commits exactly once per bus cycle. The
// done flag blocks further commits until the request drops.
module slow_set
  import set_pkg::*;
#(
  parameter int             NCH    = NCH_DEF,
  parameter int             TW     = TW_DEF,
  parameter logic [NCH-1:0] RST_EN = RST_EN_DEF,
  parameter logic [TW-1:0]  RST_TO = RST_TO_DEF
) (
  input  logic                            CLK,
  input  logic                            nPOR,
  input  logic                            BACT,
  input  logic                            SetCSWR,
  input  logic [lock_bit(NCH, TW):EN_LSB] A,
  input  logic [NCH-1:0]                  DevAcc,
  input  logic                            Tick,
  output logic [NCH-1:0]                  SlowEn,
  output logic [TW-1:0]                   SlowTimeout,
  output logic                            SlowHold,
  output logic                            Locked
);

  localparam int TO_POS   = to_lsb(NCH);
  localparam int LOCK_POS = lock_bit(NCH, TW);

  logic                   wr_req_q, wr_req_d;
  logic                   wr_done_q, wr_done_d;
  logic [LOCK_POS:EN_LSB] alat_q, alat_d;
  logic [NCH-1:0]         en_q, en_d;
  logic [TW-1:0]          to_q, to_d;
  logic                   commit;
  logic                   locked;
  logic                   load;

  // Write front end: register the request and address, fire one commit.
  always_comb begin
    wr_req_d  = BACT && SetCSWR;
    alat_d    = A;
    commit    = wr_req_q && !wr_done_q && !locked;
    wr_done_d = wr_req_q ? (wr_done_q || commit) : 1'b0;
  end

  // Settings next-state: load both fields from the latched address on commit.
  always_comb begin
    en_d = en_q;
    to_d = to_q;
    if (commit) begin
      en_d = alat_q[TO_POS-1:EN_LSB];
      to_d = alat_q[LOCK_POS-1:TO_POS];
    end
  end

  // Front-end and settings registers, synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nPOR) begin
      wr_req_q  <= 1'b0;
      wr_done_q <= 1'b0;
      alat_q    <= '0;
      en_q      <= RST_EN;
      to_q      <= RST_TO;
    end else begin
      wr_req_q  <= wr_req_d;
      wr_done_q <= wr_done_d;
      alat_q    <= alat_d;
      en_q      <= en_d;
      to_q      <= to_d;
    end
  end

`ifdef SET_LOCK_EN
  logic locked_q, locked_d;

  // Lock is set by the same commit that writes the fields; only reset clears it.
  always_comb begin
    locked_d = locked_q || (commit && alat_q[LOCK_POS]);
  end

  // Lock register, synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nPOR) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  // Lock request bit is latched with the rest of the address but has no effect.
  logic unused_lock;
  assign unused_lock = alat_q[LOCK_POS];
  assign locked      = 1'b0;
`endif

  // An access to any slow-enabled channel (re)starts the hold timeout.
  assign load = |(DevAcc & en_q);

  slow_timer #(
    .TW (TW)
  ) u_timer (
    .CLK     (CLK),
    .nPOR    (nPOR),
    .Load    (load),
    .LoadVal (to_q),
    .Tick    (Tick),
    .Hold    (SlowHold)
  );

  assign SlowEn      = en_q;
  assign SlowTimeout = to_q;
  assign Locked      = locked;

endmodule

// File: tb/tb_slow_set.sv
// tb_slow_set: directed bench for slow_set with hand-computed expectations.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_slow_set;

  logic        clk;
  logic        npor;
  logic        bact;
  logic        setcswr;
  logic [12:1] a;
  logic [6:0]  devacc;
  logic        tick;
  logic [6:0]  slow_en;
  logic [3:0]  slow_to;
  logic        slow_hold;
  logic        locked;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected lock behaviour depends on whether the lock feature is built in.
`ifdef SET_LOCK_EN
  localparam bit LOCK_BUILT = 1'b1;
`else
  localparam bit LOCK_BUILT = 1'b0;
`endif

  slow_set dut (
    .CLK         (clk),
    .nPOR        (npor),
    .BACT        (bact),
    .SetCSWR     (setcswr),
    .A           (a),
    .DevAcc      (devacc),
    .Tick        (tick),
    .SlowEn      (slow_en),
    .SlowTimeout (slow_to),
    .SlowHold    (slow_hold),
    .Locked      (locked)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single checking point for every comparison.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bus write held for 'cycles' clocks, then two idle clocks.
  task automatic write_cfg(input logic lock, input logic [3:0] to, input logic [6:0] en,
                           input int cycles);
    @(negedge clk);
    bact    = 1'b1;
    setcswr = 1'b1;
    a       = {lock, to, en};
    repeat (cycles) @(negedge clk);
    bact    = 1'b0;
    setcswr = 1'b0;
    a       = '0;
    idle(2);
  endtask

  task automatic dev_pulse(input logic [6:0] mask);
    @(negedge clk);
    devacc = mask;
    @(negedge clk);
    devacc = '0;
  endtask

  task automatic tick_pulse();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    npor = 1'b0; bact = 1'b0; setcswr = 1'b0; a = '0; devacc = '0; tick = 1'b0;
    idle(3);

    // Reset values
    check("rst_en",     32'(slow_en),   32'h3F);
    check("rst_to",     32'(slow_to),   32'h3);
    check("rst_hold",   32'(slow_hold), 32'h0);
    check("rst_locked", 32'(locked),    32'h0);

    npor = 1'b1;
    idle(1);

    // Long write: one commit at edge n+1, later address changes ignored
    bact = 1'b1; setcswr = 1'b1; a = {1'b0, 4'h5, 7'h41};
    @(negedge clk);
    check("wr_pre_en", 32'(slow_en), 32'h3F);
    a = {1'b0, 4'hA, 7'h7F};
    @(negedge clk);
    check("wr_n1_en", 32'(slow_en), 32'h41);
    check("wr_n1_to", 32'(slow_to), 32'h5);
    a = {1'b0, 4'hC, 7'h12};
    idle(3);
    check("wr_hold_en", 32'(slow_en), 32'h41);
    check("wr_hold_to", 32'(slow_to), 32'h5);
    bact = 1'b0; setcswr = 1'b0; a = '0;
    idle(2);
    check("wr_end_to", 32'(slow_to), 32'h5);

    // Timeout of 4 ticks, ticks spaced 10 cycles apart
    write_cfg(1'b0, 4'h4, 7'h08, 2);
    check("cfg4_en", 32'(slow_en), 32'h08);
    check("cfg4_to", 32'(slow_to), 32'h4);
    dev_pulse(7'h08);
    check("acc_hold", 32'(slow_hold), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      idle(9);
      check($sformatf("gap%0d_hold", i), 32'(slow_hold), 32'h1);
      tick_pulse();
      check($sformatf("tick%0d_hold", i), 32'(slow_hold), (i < 4) ? 32'h1 : 32'h0);
    end

    // Access to a channel that is not slow-enabled does nothing
    dev_pulse(7'h04);
    check("dis_ch_hold", 32'(slow_hold), 32'h0);

    // Reload at count 1 coincident with a tick
    dev_pulse(7'h08);
    repeat (3) tick_pulse();
    check("cnt1_hold", 32'(slow_hold), 32'h1);
    @(negedge clk);
    devacc = 7'h08; tick = 1'b1;
    @(negedge clk);
    devacc = '0; tick = 1'b0;
    check("reload_hold", 32'(slow_hold), 32'h1);
    repeat (3) tick_pulse();
    check("reload_t3", 32'(slow_hold), 32'h1);
    tick_pulse();
    check("reload_t4", 32'(slow_hold), 32'h0);

    // Commit during a count keeps the count; new timeout applies on next load
    dev_pulse(7'h08);
    write_cfg(1'b0, 4'h2, 7'h08, 2);
    check("mid_to", 32'(slow_to), 32'h2);
    repeat (3) tick_pulse();
    check("mid_t3", 32'(slow_hold), 32'h1);
    tick_pulse();
    check("mid_t4", 32'(slow_hold), 32'h0);
    dev_pulse(7'h08);
    tick_pulse();
    check("new_t1", 32'(slow_hold), 32'h1);
    tick_pulse();
    check("new_t2", 32'(slow_hold), 32'h0);

    // Zero timeout never raises hold
    write_cfg(1'b0, 4'h0, 7'h08, 2);
    dev_pulse(7'h08);
    check("to0_hold", 32'(slow_hold), 32'h0);
    idle(1);
    check("to0_hold2", 32'(slow_hold), 32'h0);

    // Reset mid-count (count 3) and mid-write: write is lost
    write_cfg(1'b0, 4'h4, 7'h08, 2);
    dev_pulse(7'h08);
    tick_pulse();
    check("pre_rst_hold", 32'(slow_hold), 32'h1);
    @(negedge clk);
    bact = 1'b1; setcswr = 1'b1; a = {1'b0, 4'hE, 7'h55}; npor = 1'b0;
    @(negedge clk);
    check("mrst_en",   32'(slow_en),   32'h3F);
    check("mrst_to",   32'(slow_to),   32'h3);
    check("mrst_hold", 32'(slow_hold), 32'h0);
    npor = 1'b1; bact = 1'b0; setcswr = 1'b0; a = '0;
    idle(2);
    check("lost_wr_en", 32'(slow_en), 32'h3F);
    check("lost_wr_to", 32'(slow_to), 32'h3);

    // Lock: write-once when built in, ignored otherwise
    write_cfg(1'b1, 4'h2, 7'h7F, 2);
    check("lock_to",  32'(slow_to), 32'h2);
    check("lock_set", 32'(locked),  32'(LOCK_BUILT));
    write_cfg(1'b0, 4'h9, 7'h01, 2);
    check("after_lock_to", 32'(slow_to), LOCK_BUILT ? 32'h2 : 32'h9);
    check("after_lock_en", 32'(slow_en), LOCK_BUILT ? 32'h7F : 32'h01);
    check("after_lock_lk", 32'(locked),  32'(LOCK_BUILT));
    @(negedge clk);
    npor = 1'b0;
    @(negedge clk);
    check("unlock_rst", 32'(locked), 32'h0);
    npor = 1'b1;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
